// File: rtl/quan_e_loader.sv
// quan_e_loader: fills the per-tile E-scale register bank from the on-chip E buffer.
// Mode 0 writes 2 words of 32 entries each; mode 1 writes 4 words of 16 entries each.
module quan_e_loader #(
  parameter int E_word_width  = 512,
  parameter int E_addr_width  = 12,
  parameter int sa_row_num    = 4,
  parameter int row_num_in_sa = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [3:0]              mode,
  input  logic [E_addr_width-1:0] E_base_addr,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    err_mode,
  output logic                    E_rd_en,
  output logic [E_addr_width-1:0] E_rd_addr,
  input  logic                    E_rd_valid,
  input  logic [E_word_width-1:0] E_rd_data,
  output logic                    E_set,
  output logic [3:0]              E_mode,
  output logic [E_word_width-1:0] E_word,
  output logic [7:0]              E_reg_start,
  output logic [7:0]              E_reg_size
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int         bank_entries = sa_row_num * row_num_in_sa;
  localparam logic [7:0] size_mode0   = 8'(bank_entries / 2);
  localparam logic [7:0] size_mode1   = 8'(bank_entries / 4);

  logic [1:0]              state;
  logic [2:0]              index;
  logic [E_addr_width-1:0] base;
  logic                    wide;
  logic                    err_pending;

  logic [2:0] index_next;
  logic [2:0] word_count;
  logic [7:0] cur_size;

  assign index_next = index + 3'd1;
  assign word_count = wide ? 3'd4 : 3'd2;
  assign cur_size   = wide ? size_mode1 : size_mode0;

  // An illegal mode spends one cycle in DONE with err_pending set, then pulses
  // load_done and err_mode together; a legal load enters DONE with load_done already high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      index       <= 3'd0;
      base        <= '0;
      wide        <= 1'b0;
      err_pending <= 1'b0;
      load_busy   <= 1'b0;
      load_done   <= 1'b0;
      err_mode    <= 1'b0;
      E_rd_en     <= 1'b0;
      E_rd_addr   <= '0;
      E_set       <= 1'b0;
      E_mode      <= 4'd0;
      E_word      <= '0;
      E_reg_start <= 8'd0;
      E_reg_size  <= 8'd0;
    end else begin
      E_rd_en   <= 1'b0;
      E_set     <= 1'b0;
      load_done <= 1'b0;
      err_mode  <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            base      <= E_base_addr;
            index     <= 3'd0;
            load_busy <= 1'b1;
            if (mode == 4'd0 || mode == 4'd1) begin
              wide      <= (mode == 4'd1);
              E_mode    <= mode;
              E_rd_en   <= 1'b1;
              E_rd_addr <= E_base_addr;
              state     <= WAIT;
            end else begin
              err_pending <= 1'b1;
              state       <= DONE;
            end
          end
        end
        WAIT: begin
          if (E_rd_valid) begin
            E_word      <= E_rd_data;
            E_set       <= 1'b1;
            E_reg_start <= 8'd1 + cur_size * {5'd0, index};
            E_reg_size  <= cur_size;
            state       <= WRITE;
          end
        end
        WRITE: begin
          index <= index_next;
          if (index_next == word_count) begin
            load_done <= 1'b1;
            state     <= DONE;
          end else begin
            E_rd_en   <= 1'b1;
            E_rd_addr <= base + E_addr_width'(index_next);
            state     <= WAIT;
          end
        end
        default: begin
          if (err_pending) begin
            err_pending <= 1'b0;
            load_done   <= 1'b1;
            err_mode    <= 1'b1;
          end else begin
            load_busy <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
